// File: rtl/spi_nor_writer_if.sv
// Byte-level SPI master link and on-chip memory read port of the NOR page writer.
//
// Toggle handshake: the link is idle while spi_req == spi_ack. The writer
// launches a byte by loading spi_d and inverting spi_req in the same cycle;
// the master finishes it by making spi_ack equal spi_req, and spi_q is valid
// from that point. spi_ack never matches earlier than the cycle after the
// toggle. spi_cs_n only changes while the link is idle.
interface spi_nor_writer_if #(
  parameter int MEM_AW = 16
);
  logic              spi_req;
  logic              spi_ack;
  logic [7:0]        spi_d;
  logic [7:0]        spi_q;
  logic              spi_cs_n;
  logic [MEM_AW-1:0] mem_a;
  logic [7:0]        mem_d;

  modport master (
    output spi_req, spi_d, spi_cs_n, mem_a,
    input  spi_ack, spi_q, mem_d
  );

  modport slave (
    input  spi_req, spi_d, spi_cs_n, mem_a,
    output spi_ack, spi_q, mem_d
  );
endinterface

// File: rtl/spi_nor_writer.sv
// Programs one page of SPI NOR flash from on-chip memory: optional sector
// erase, then WREN + Page Program, each followed by a status-poll wait.
module spi_nor_writer #(
  parameter int         ADDRCNT  = 3,
  parameter int         MEM_AW   = 16,
  parameter logic [7:0] PP_CMD   = 8'h02,
  parameter logic [7:0] SE_CMD   = 8'h20,
  parameter int         POLL_MAX = 65535
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_i,
  input  logic                   erase_i,
  input  logic [ADDRCNT*8-1:0]   spi_addr_i,
  input  logic [MEM_AW-1:0]      mem_start_i,
  input  logic [8:0]             len_i,
  spi_nor_writer_if.master       bus,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [2:0]             state_o
);

  localparam int         PW        = $clog2(POLL_MAX + 1);
  localparam logic [2:0] ADDR_LAST = 3'(ADDRCNT);
  localparam logic [2:0] DATA_IDX  = 3'(ADDRCNT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_CSLOW, S_SEND, S_ACK, S_GAP
  } state_t;

  // Frame sequence of one job; the erase steps are skipped when erase=0.
  typedef enum logic [2:0] {
    ST_E_WREN, ST_SE, ST_E_WAIT, ST_P_WREN, ST_PP, ST_P_WAIT
  } step_t;

  state_t                state_q;
  step_t                 step_q;
  step_t                 next_step;
  logic                  erase_q;
  logic [ADDRCNT*8-1:0]  addr_q;
  logic [8:0]            len_q;
  logic [2:0]            idx_q;       // 0 opcode, 1..ADDRCNT address, DATA_IDX payload/poll
  logic [8:0]            data_cnt_q;
  logic [PW-1:0]         poll_cnt_q;
  logic                  gap_q;
  logic                  req_q;
  logic [7:0]            d_q;
  logic                  cs_n_q;
  logic [MEM_AW-1:0]     mem_a_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;

  logic                  finish_next;
  logic                  is_wait;
  logic                  range_err;
  logic [7:0]            opcode;
  logic [ADDRCNT*8-1:0]  addr_sh;
  logic                  unused_status;

  assign is_wait       = (step_q == ST_E_WAIT) || (step_q == ST_P_WAIT);
  assign range_err     = (len_q != 9'd0) &&
                         (({2'b00, addr_q[7:0]} + {1'b0, len_q}) > 10'd256);
  assign unused_status = ^bus.spi_q[7:1];

  // Opcode, address byte (MSB first) and successor step for the current frame.
  always_comb begin
    next_step   = step_q;
    finish_next = 1'b0;
    opcode      = 8'h06;
    addr_sh     = addr_q >> (8 * (ADDRCNT - int'(idx_q)));
    case (step_q)
      ST_E_WREN: next_step = ST_SE;
      ST_SE: begin
        opcode    = SE_CMD;
        next_step = ST_E_WAIT;
      end
      ST_E_WAIT: begin
        opcode = 8'h05;
        if (len_q != 9'd0) next_step = ST_P_WREN;
        else               finish_next = 1'b1;
      end
      ST_P_WREN: next_step = ST_PP;
      ST_PP: begin
        opcode    = PP_CMD;
        next_step = ST_P_WAIT;
      end
      default: begin
        opcode      = 8'h05;
        finish_next = 1'b1;
      end
    endcase
  end

  // Job sequencer: frames, byte launches, status polling and completion.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      step_q     <= ST_E_WREN;
      erase_q    <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      data_cnt_q <= '0;
      poll_cnt_q <= '0;
      gap_q      <= 1'b0;
      req_q      <= 1'b0;
      d_q        <= 8'h00;
      cs_n_q     <= 1'b1;
      mem_a_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            erase_q <= erase_i;
            addr_q  <= spi_addr_i;
            len_q   <= len_i;
            mem_a_q <= mem_start_i;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (range_err) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (erase_q) begin
            step_q  <= ST_E_WREN;
            state_q <= S_CSLOW;
          end else if (len_q != 9'd0) begin
            step_q  <= ST_P_WREN;
            state_q <= S_CSLOW;
          end else begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_CSLOW: begin
          cs_n_q     <= 1'b0;
          idx_q      <= '0;
          data_cnt_q <= '0;
          poll_cnt_q <= '0;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          req_q   <= ~req_q;
          state_q <= S_ACK;
          if (idx_q == 3'd0) begin
            d_q <= opcode;
          end else if (idx_q <= ADDR_LAST) begin
            d_q <= addr_sh[7:0];
          end else if (is_wait) begin
            d_q <= 8'hFF;
          end else begin
            // Memory data for mem_a_q has been stable since the previous launch.
            d_q        <= bus.mem_d;
            mem_a_q    <= mem_a_q + 1'b1;
            data_cnt_q <= data_cnt_q + 1'b1;
          end
        end
        S_ACK: begin
          if (req_q == bus.spi_ack) begin
            if (is_wait) begin
              if (idx_q == 3'd0) begin
                idx_q   <= DATA_IDX;
                state_q <= S_SEND;
              end else if (!bus.spi_q[0]) begin
                cs_n_q  <= 1'b1;
                gap_q   <= 1'b0;
                state_q <= S_GAP;
              end else if (poll_cnt_q == POLL_LAST) begin
                cs_n_q  <= 1'b1;
                error_q <= 1'b1;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                poll_cnt_q <= poll_cnt_q + 1'b1;
                state_q    <= S_SEND;
              end
            end else if ((step_q == ST_SE || step_q == ST_PP) && idx_q < ADDR_LAST) begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_SEND;
            end else if (step_q == ST_PP && data_cnt_q != len_q) begin
              idx_q   <= DATA_IDX;
              state_q <= S_SEND;
            end else begin
              cs_n_q  <= 1'b1;
              gap_q   <= 1'b0;
              state_q <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (!gap_q) begin
            gap_q <= 1'b1;
          end else if (finish_next) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            step_q  <= next_step;
            state_q <= S_CSLOW;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.spi_req  = req_q;
  assign bus.spi_d    = d_q;
  assign bus.spi_cs_n = cs_n_q;
  assign bus.mem_a    = mem_a_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign state_o      = state_q;

endmodule

// File: doc/spi_nor_writer.md
Name: spi_nor_writer

Overview:
- Programs one page of SPI NOR flash from on-chip memory; write-direction counterpart of the flash loader.
- Shares the same byte-level toggle-handshake SPI master.
- Per job: optional 4 KiB sector erase, then WREN + Page Program, then a status-poll wait for completion.
- Sits beside the loader; a top-level mux grants the SPI master to one of them.

Parameters:
- ADDRCNT, 3, flash address bytes (3 or 4).
- MEM_AW, 16, memory address width.
- PP_CMD, 8'h02, page program opcode.
- SE_CMD, 8'h20, sector erase opcode.
- POLL_MAX, 65535, max status bytes read per wait before error.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  one-cycle job request
- erase  in  1  erase sector before programming (sampled at start)
- spi_addr  in  ADDRCNT*8  flash byte address (sampled at start)
- mem_start  in  MEM_AW  first memory address (sampled at start)
- len  in  9  byte count 0..256 (sampled at start)
- spi_req  out  1  toggles to launch a byte transfer
- spi_ack  in  1  byte done when equal to spi_req
- spi_d  out  8  byte to send
- spi_q  in  8  byte received, valid when spi_ack==spi_req
- spi_cs_n  out  1  flash chip select
- mem_a  out  MEM_AW  memory read address
- mem_d  in  8  memory data; 1-cycle registered read latency
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- error  out  1  sticky until next accepted start

Behaviour:
- Reset (reset_n=0 at posedge): spi_req=0, spi_d=0, spi_cs_n=1, mem_a=0, busy=0, done=0, error=0, state=IDLE.
  - Mid-job reset aborts immediately and raises CS.
  - The SPI master shares this reset.
- Link idle = (spi_req==spi_ack). Launch a byte: load spi_d, toggle spi_req in the same cycle. spi_ack never matches earlier than the cycle after the toggle.
- spi_cs_n changes only while the link is idle.
- Every CS rise holds CS high for at least 2 cycles (state CSGAP) before the next fall.
- IDLE: start=1 latches all inputs, mem_a<=mem_start, error<=0, busy<=1 next cycle. start while busy is ignored.
- Range check at start: if len!=0 and spi_addr[7:0]+len>256 → error=1, done pulse, no SPI activity.
- Job with erase=0 and len=0 → done next cycle, no SPI activity.
- Erase phase (erase=1):
  - CS low; send 06; CS high; CSGAP.
  - CS low; send SE_CMD; send address MSB first (ADDRCNT bytes); CS high; CSGAP; WAIT.
- Program phase (len!=0):
  - CS low; send 06; CS high; CSGAP.
  - CS low; send PP_CMD; send address bytes; send len data bytes.
  - Each data byte: spi_d<=mem_d, mem_a<=mem_a+1, toggle spi_req.
  - After the last byte completes: CS high; CSGAP; WAIT.
- WAIT:
  - CS low; send 05; then send FF repeatedly, CS held low.
  - Each completed FF transfer counts one poll and examines spi_q bit0 (WIP).
  - WIP=0 → CS high, go to next phase or finish.
  - Poll count reaching POLL_MAX with WIP still 1 → CS high, error=1, done pulse, job aborted.
  - Poll counter clears at each WAIT entry.
- Finish: CS high, done=1 for one cycle, busy=0 in the same cycle, return to IDLE.
- mem_a after a successful program = mem_start+len, with MEM_AW wrap (mem_start=max wraps to 0).
- len=256 uses the full 9-bit count; byte counter is 9 bits.

Test Plan:
- erase=0, spi_addr=0x012300, len=4, mem[0x10..0x13]=A1 B2 C3 D4, model ack 3 cycles after req, WIP=1 for 2 polls → SPI stream [06] [02 01 23 00 A1 B2 C3 D4] [05 FF FF FF]; done once; error=0; mem_a=0x14.
- erase=1, len=1 → [06][20 addr][05 FF..][06][02 addr byte][05 FF..]; CS high ≥2 cycles between every frame.
- spi_addr[7:0]=0xF0, len=17 → error=1, done pulse, spi_req never toggles; len=16 at the same address succeeds.
- len=256, spi_addr[7:0]=0, mem_start=0xFF80 → 256 data bytes sent; mem_a wraps through 0 and ends at 0x0080.
- POLL_MAX=4 with WIP stuck at 1 → exactly 4 FF polls, then CS high, error=1, done pulse.
- reset_n low during the data phase → spi_cs_n=1 the next cycle and all outputs at reset values; start while busy → ignored, job result unchanged.
